// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
// Shared types and helper functions for the fetch sequencer and its
// return-address stack.
//   fetchState_t : sequencer states (IDLE, ARMED, RUN, HALTED)
//   pcSel_t      : next-PC source chosen by the priority logic
//   depthWidth() : bits needed to count 0..depth occupied entries
//   indexWidth() : bits needed to address depth storage slots (min 1)
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        HALTED
    } fetchState_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_ABS,
        SEL_REL,
        SEL_CALL,
        SEL_RET
    } pcSel_t;

    function automatic int depthWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int indexWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
// LIFO of DEPTH entries, each WIDTH bits, holding return addresses.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset (empty)
//   push, din    : write din on top of the stack
//   pop          : discard the top entry
//   clear        : empty the stack (wins over push/pop)
//   top          : current top entry (undefined when empty)
//   depth        : number of occupied entries
//   full, empty  : occupancy flags
// A push while full or a pop while empty is silently dropped; the caller is
// responsible for flagging those as errors.
// ---------------------------------------------------------------------------
module ret_addr_stack
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int DW = depthWidth(DEPTH);
    localparam int IW = indexWidth(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    count;
    logic [IW-1:0]    wrIdx;
    logic [IW-1:0]    rdIdx;
    logic             doPush;
    logic             doPop;

    // The count doubles as the write pointer; the entry just below it is
    // the top. Pop wins if both requests arrive together.
    assign full   = (count == DW'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty && !clear;
    assign doPush = push && !pop && !full && !clear;
    assign wrIdx  = IW'(count);
    assign rdIdx  = IW'(count - DW'(1));
    assign top    = mem[rdIdx];
    assign depth  = count;

    // Occupancy counter: the only stack state that needs a reset, since
    // stale entries above the count are never read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (doPop) begin
            count <= count - DW'(1);
        end else if (doPush) begin
            count <= count + DW'(1);
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrIdx] <= din;
        end
    end

endmodule

// File: rtl/inst_fetch_stack.sv
// ---------------------------------------------------------------------------
// inst_fetch_stack
// Program counter and fetch sequencer with a hardware return-address stack.
// Ports:
//   Clk, Reset        : rising-edge clock, asynchronous active-high reset
//   Start             : hold/restart; a high-then-low pulse launches execution
//   Stall             : freeze PC, stack and state for the cycle (RUN only)
//   Halt              : end of program, enter HALTED
//   BranchAbs, Target : absolute jump to Target
//   BranchRelEn,
//   ALU_flag          : relative jump by two's-complement Target when flag set
//   Call, Ret         : push PC+1 and jump to Target / pop into ProgCtr
//   ProgCtr           : registered program counter
//   Done              : high while HALTED
//   StackDepth        : occupied return-address entries
//   StackErr          : sticky overflow/underflow flag, cleared by Start
// All outputs come straight from registers; every decision lands on the
// next rising edge.
// ---------------------------------------------------------------------------
module inst_fetch_stack
    import inst_fetch_pkg::*;
#(
    parameter int          PC_W        = 10,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               Start,
    input  logic                               Stall,
    input  logic                               Halt,
    input  logic                               BranchAbs,
    input  logic                               BranchRelEn,
    input  logic                               ALU_flag,
    input  logic                               Call,
    input  logic                               Ret,
    input  logic [PC_W-1:0]                    Target,
    output logic [PC_W-1:0]                    ProgCtr,
    output logic                               Done,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   StackDepth,
    output logic                               StackErr
);

    fetchState_t     state;
    fetchState_t     nextState;
    pcSel_t          pcSel;
    logic [PC_W-1:0] nextPc;
    logic [PC_W-1:0] pcInc;
    logic [PC_W-1:0] pcRel;
    logic [PC_W-1:0] stackTop;
    logic            stackPush;
    logic            stackPop;
    logic            stackClear;
    logic            stackFull;
    logic            stackEmpty;
    logic            setErr;
    logic            clrErr;

    // Sums wrap naturally at PC_W bits, so a Target of all ones acts as -1.
    assign pcInc = ProgCtr + PC_W'(1);
    assign pcRel = ProgCtr + Target;
    assign Done  = (state == HALTED);

    ret_addr_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_stack (
        .clock (Clk),
        .reset (Reset),
        .push  (stackPush),
        .pop   (stackPop),
        .clear (stackClear),
        .din   (pcInc),
        .top   (stackTop),
        .depth (StackDepth),
        .full  (stackFull),
        .empty (stackEmpty)
    );

    // Sequencer and priority decode. Start overrides everything and rearms
    // the machine with a clean stack. In RUN the first matching control wins:
    // Stall, Halt, Ret, Call, BranchAbs, qualified relative branch, increment.
    // A Call on a full stack still jumps but is not recorded; a Ret on an
    // empty stack falls through to the next instruction. Both raise the
    // sticky error.
    always_comb begin
        nextState  = state;
        pcSel      = SEL_HOLD;
        stackPush  = 1'b0;
        stackPop   = 1'b0;
        stackClear = 1'b0;
        setErr     = 1'b0;
        clrErr     = 1'b0;
        if (Start) begin
            nextState  = ARMED;
            stackClear = 1'b1;
            clrErr     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    pcSel = SEL_HOLD;
                end
                ARMED: begin
                    nextState = RUN;
                    pcSel     = SEL_INC;
                end
                RUN: begin
                    if (Stall) begin
                        pcSel = SEL_HOLD;
                    end else if (Halt) begin
                        nextState = HALTED;
                    end else if (Ret) begin
                        if (stackEmpty) begin
                            pcSel  = SEL_INC;
                            setErr = 1'b1;
                        end else begin
                            pcSel    = SEL_RET;
                            stackPop = 1'b1;
                        end
                    end else if (Call) begin
                        if (stackFull) begin
                            pcSel  = SEL_ABS;
                            setErr = 1'b1;
                        end else begin
                            pcSel     = SEL_CALL;
                            stackPush = 1'b1;
                        end
                    end else if (BranchAbs) begin
                        pcSel = SEL_ABS;
                    end else if (BranchRelEn && ALU_flag) begin
                        pcSel = SEL_REL;
                    end else begin
                        pcSel = SEL_INC;
                    end
                end
                default: begin
                    pcSel = SEL_HOLD;
                end
            endcase
        end
    end

    // Next-PC multiplexer driven by the decoded select.
    always_comb begin
        nextPc = ProgCtr;
        case (pcSel)
            SEL_INC:  nextPc = pcInc;
            SEL_ABS:  nextPc = Target;
            SEL_REL:  nextPc = pcRel;
            SEL_CALL: nextPc = Target;
            SEL_RET:  nextPc = stackTop;
            default:  nextPc = ProgCtr;
        endcase
    end

    // State, PC and sticky error registers. Clearing on Start takes
    // precedence over any error that might be raised the same cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            ProgCtr  <= PC_W'(RESET_PC);
            StackErr <= 1'b0;
        end else begin
            state   <= nextState;
            ProgCtr <= nextPc;
            if (clrErr) begin
                StackErr <= 1'b0;
            end else if (setErr) begin
                StackErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_stack.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_stack
// Directed walk through the fetch sequencer's main behaviours with literal
// expectations, followed by randomized control traffic compared each cycle
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_inst_fetch_stack;

    localparam int PC_W        = 10;
    localparam int STACK_DEPTH = 4;
    localparam int RESET_PC    = 0;
    localparam int DW          = $clog2(STACK_DEPTH + 1);
    localparam int PC_MOD      = 1 << PC_W;

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_RUN    = 2;
    localparam int M_HALTED = 3;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic            Stall;
    logic            Halt;
    logic            BranchAbs;
    logic            BranchRelEn;
    logic            ALU_flag;
    logic            Call;
    logic            Ret;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic            Done;
    logic [DW-1:0]   StackDepth;
    logic            StackErr;

    int vectors     = 0;
    int miscompares = 0;

    int mState;
    int mPc;
    int mStack[$];
    bit mErr;
    bit modelCheckEn = 1'b0;

    inst_fetch_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .Halt        (Halt),
        .BranchAbs   (BranchAbs),
        .BranchRelEn (BranchRelEn),
        .ALU_flag    (ALU_flag),
        .Call        (Call),
        .Ret         (Ret),
        .Target      (Target),
        .ProgCtr     (ProgCtr),
        .Done        (Done),
        .StackDepth  (StackDepth),
        .StackErr    (StackErr)
    );

    always #5 Clk = ~Clk;

    // One comparison of an observed value against its expectation.
    task automatic checkField(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare all four outputs against a set of expectations.
    task automatic checkOutput(input string tag, input int pc, input int depth,
                               input int err, input int done);
        checkField({tag, ".ProgCtr"},    int'(ProgCtr),    pc);
        checkField({tag, ".StackDepth"}, int'(StackDepth), depth);
        checkField({tag, ".StackErr"},   int'(StackErr),   err);
        checkField({tag, ".Done"},       int'(Done),       done);
    endtask

    // Reference model: the architectural state as the behaviour rules
    // describe it, with the return stack as a plain queue.
    task automatic modelReset();
        mState = M_IDLE;
        mPc    = RESET_PC;
        mStack.delete();
        mErr   = 1'b0;
    endtask

    task automatic modelStep();
        if (Start) begin
            mState = M_ARMED;
            mStack.delete();
            mErr   = 1'b0;
        end else if (mState == M_ARMED) begin
            mState = M_RUN;
            mPc    = (mPc + 1) % PC_MOD;
        end else if (mState == M_RUN && !Stall) begin
            if (Halt) begin
                mState = M_HALTED;
            end else if (Ret) begin
                if (mStack.size() == 0) begin
                    mErr = 1'b1;
                    mPc  = (mPc + 1) % PC_MOD;
                end else begin
                    mPc = mStack.pop_back();
                end
            end else if (Call) begin
                if (mStack.size() == STACK_DEPTH) mErr = 1'b1;
                else mStack.push_back((mPc + 1) % PC_MOD);
                mPc = int'(Target);
            end else if (BranchAbs) begin
                mPc = int'(Target);
            end else if (BranchRelEn && ALU_flag) begin
                mPc = (mPc + int'(Target)) % PC_MOD;
            end else begin
                mPc = (mPc + 1) % PC_MOD;
            end
        end
    endtask

    always @(posedge Reset) modelReset();

    // Compare process: advance the model on each edge, then check the DUT
    // shortly after the edge once the outputs have settled.
    always @(posedge Clk) begin
        if (Reset) modelReset();
        else modelStep();
        #1;
        if (modelCheckEn) begin
            checkOutput("model", mPc, mStack.size(), int'(mErr), int'(mState == M_HALTED));
        end
    end

    task automatic clearInputs();
        Start       = 1'b0;
        Stall       = 1'b0;
        Halt        = 1'b0;
        BranchAbs   = 1'b0;
        BranchRelEn = 1'b0;
        ALU_flag    = 1'b0;
        Call        = 1'b0;
        Ret         = 1'b0;
        Target      = '0;
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Random control traffic. Stall is held low while arming so the launch
    // cycle is always a clean increment.
    task automatic applyStimulus();
        Reset       = ($urandom_range(0, 499) == 0);
        Start       = ($urandom_range(0, 24) == 0) ||
                      (mState == M_HALTED && $urandom_range(0, 5) == 0) ||
                      (mState == M_IDLE && $urandom_range(0, 2) == 0);
        Stall       = (mState == M_ARMED) ? 1'b0 : ($urandom_range(0, 7) == 0);
        Halt        = ($urandom_range(0, 39) == 0);
        Ret         = ($urandom_range(0, 5) == 0);
        Call        = ($urandom_range(0, 4) == 0);
        BranchAbs   = ($urandom_range(0, 7) == 0);
        BranchRelEn = ($urandom_range(0, 3) == 0);
        ALU_flag    = 1'($urandom_range(0, 1));
        Target      = PC_W'($urandom_range(0, PC_MOD - 1));
    endtask

    initial begin
        // Reset with every control high.
        Reset       = 1'b1;
        Start       = 1'b1;
        Stall       = 1'b1;
        Halt        = 1'b1;
        BranchAbs   = 1'b1;
        BranchRelEn = 1'b1;
        ALU_flag    = 1'b1;
        Call        = 1'b1;
        Ret         = 1'b1;
        Target      = 10'h3FF;
        tick();
        checkOutput("reset", 0, 0, 0, 0);
        Reset = 1'b0;
        clearInputs();
        modelCheckEn = 1'b1;
        tick();
        checkOutput("idle", 0, 0, 0, 0);

        // Launch and default increment.
        Start = 1'b1;
        tick(); checkOutput("armed0", 0, 0, 0, 0);
        tick(); checkOutput("armed1", 0, 0, 0, 0);
        Start = 1'b0;
        tick(); checkOutput("launch", 1, 0, 0, 0);
        tick(); checkOutput("inc2", 2, 0, 0, 0);
        tick(); checkOutput("inc3", 3, 0, 0, 0);

        // Absolute and relative branches.
        BranchAbs = 1'b1; Target = 10'h011;
        tick(); checkOutput("abs", 'h011, 0, 0, 0);
        BranchAbs = 1'b0; BranchRelEn = 1'b1; ALU_flag = 1'b0;
        tick(); checkOutput("relNotTaken", 'h012, 0, 0, 0);
        ALU_flag = 1'b1; Target = 10'h3FE;
        tick(); checkOutput("relMinus2", 'h010, 0, 0, 0);
        BranchRelEn = 1'b0; ALU_flag = 1'b0;

        // Increment wrap.
        BranchAbs = 1'b1; Target = 10'h3FF;
        tick(); checkOutput("toTop", 'h3FF, 0, 0, 0);
        BranchAbs = 1'b0;
        tick(); checkOutput("wrap", 'h000, 0, 0, 0);

        // Nested call/return and underflow.
        BranchAbs = 1'b1; Target = 10'h005;
        tick(); checkOutput("pc5", 'h005, 0, 0, 0);
        BranchAbs = 1'b0; Call = 1'b1; Target = 10'h040;
        tick(); checkOutput("call1", 'h040, 1, 0, 0);
        Target = 10'h080;
        tick(); checkOutput("call2", 'h080, 2, 0, 0);
        Call = 1'b0; Ret = 1'b1;
        tick(); checkOutput("ret1", 'h041, 1, 0, 0);
        tick(); checkOutput("ret2", 'h006, 0, 0, 0);
        tick(); checkOutput("underflow", 'h007, 0, 1, 0);
        Ret = 1'b0;
        tick(); checkOutput("sticky", 'h008, 0, 1, 0);

        // Restart clears the error; then overflow the stack.
        Start = 1'b1;
        tick(); checkOutput("rearm", 'h008, 0, 0, 0);
        Start = 1'b0;
        tick(); checkOutput("relaunch", 'h009, 0, 0, 0);
        Call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Target = PC_W'('h100 + i);
            tick();
            checkOutput("callSeq", 'h100 + i, (i < 4) ? i + 1 : 4, (i < 4) ? 0 : 1, 0);
        end

        // Stall freezes a pending call.
        Stall = 1'b1; Target = 10'h200;
        tick(); checkOutput("stall", 'h104, 4, 1, 0);
        Stall = 1'b0;

        // Call and Ret together behave as Ret.
        Ret = 1'b1; Target = 10'h300;
        tick(); checkOutput("callRet", 'h103, 3, 1, 0);
        Call = 1'b0; Ret = 1'b0;

        // Halt, branches ignored, restart.
        Halt = 1'b1;
        tick(); checkOutput("halt", 'h103, 3, 1, 1);
        Halt = 1'b0; BranchAbs = 1'b1; Target = 10'h055;
        tick(); checkOutput("halted", 'h103, 3, 1, 1);
        Start = 1'b1;
        tick(); checkOutput("unhalt", 'h103, 0, 0, 0);
        Start = 1'b0; BranchAbs = 1'b0;
        tick(); checkOutput("resume", 'h104, 0, 0, 0);
        tick(); checkOutput("resume2", 'h105, 0, 0, 0);

        // Reset asserted in the middle of a call cycle.
        Call = 1'b1; Target = 10'h2AA;
        @(posedge Clk); #2;
        checkOutput("callDone", 'h2AA, 1, 0, 0);
        Reset = 1'b1;
        #1;
        checkOutput("asyncReset", 0, 0, 0, 0);
        tick();
        Reset = 1'b0;
        clearInputs();

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            applyStimulus();
            tick();
        end
        Reset = 1'b0;
        clearInputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_stack.md
Name: inst_fetch_stack

Overview:
Parametrised next-generation program counter and fetch sequencer with a hardware return-address stack for Call/Ret. It handles the existing fetch controls: Reset, Start hold, unconditional absolute jump, flag-qualified relative jump and default increment. It adds a Stall input, a Halt/Done state machine and stack error reporting. It sits between the decoder/ALU (control and flag sources) and instruction ROM (ProgCtr consumer).

Parameters:
PC_W, 10, width of ProgCtr and Target in bits
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_PC, 0, ProgCtr value loaded on Reset

Ports:
Clk  input  1  single clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  hold/restart request; a high-then-low pulse launches execution
Stall  input  1  freeze PC, stack and state this cycle
Halt  input  1  decoder end-of-program indication
BranchAbs  input  1  unconditional absolute jump to Target
BranchRelEn  input  1  relative branch enable, qualified by ALU_flag
ALU_flag  input  1  branch condition from ALU
Call  input  1  push return address, jump to Target
Ret  input  1  pop return address into ProgCtr
Target  input  PC_W  absolute address, or two's-complement relative offset
ProgCtr  output  PC_W  current program counter (registered)
Done  output  1  high while in HALTED state
StackDepth  output  $clog2(STACK_DEPTH+1)  occupied stack entries
StackErr  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, any time, including mid-push/pop): ProgCtr=RESET_PC, state=IDLE, StackDepth=0, StackErr=0, Done=0; stack contents don't-care.
- States: IDLE, ARMED, RUN, HALTED.
- IDLE: ProgCtr held. Start=1 -> ARMED.
- ARMED: ProgCtr held while Start=1. Start=0 -> RUN, and ProgCtr increments in this same cycle.
- Start=1 in RUN or HALTED -> ARMED, ProgCtr held, StackDepth cleared to 0, StackErr cleared. Start has priority over Stall and all branches.
- RUN, per-cycle priority (first match wins):
  - Stall: everything held.
  - Halt: HALTED, PC held.
  - Ret: pop.
  - Call: push.
  - BranchAbs: PC=Target.
  - BranchRelEn&&ALU_flag: PC=PC+Target.
  - Otherwise: PC=PC+1.
- HALTED: Done=1, PC/stack frozen, all branch inputs ignored. Exit only via Start or Reset.
- Arithmetic: all sums modulo 2^PC_W.
  - Relative add of Target=2^PC_W-1 means -1.
  - PC=2^PC_W-1 increments to 0. No wrap flag.
- Call, depth<STACK_DEPTH: push PC+1 (mod 2^PC_W), depth+1, PC=Target.
- Call, depth==STACK_DEPTH (overflow): PC=Target, stack and depth unchanged, StackErr=1.
- Ret, depth>0: PC=top entry, depth-1.
- Ret, depth==0 (underflow): PC=PC+1, StackErr=1.
- Call and Ret in the same cycle: Ret wins, Call ignored. Lower-priority inputs are always ignored when a higher one fires.
- Latency: every decision takes effect on ProgCtr at the next rising edge. No combinational path from inputs to outputs.
- StackDepth and Done are registered and consistent with ProgCtr in the same cycle.

Decomposition:
- Package inst_fetch_pkg holds:
  - the state enum (IDLE, ARMED, RUN, HALTED);
  - the next-PC select enum (HOLD, INC, ABS, REL, CALL, RET);
  - localparam helpers for depth width.
- One sub-module ret_addr_stack: LIFO of STACK_DEPTH x PC_W.
  - Inputs: push, pop, din, clear.
  - Outputs: top, depth, full, empty.
  - Asynchronous reset to empty.
  - Push when full or pop when empty is ignored internally.
- Top level: FSM, priority mux, PC register, sticky error.

Test Plan:
- Reset=1 with all controls high, Target=10'h3FF -> ProgCtr=0, Done=0, StackDepth=0. Release Reset with Start=0 -> stays 0 (IDLE).
- Start=1 for 2 cycles then 0, no branches -> ProgCtr 0,0 then 1,2,3. BranchAbs=1, Target=10'h011 -> 10'h011. BranchRelEn=1, ALU_flag=0 -> 10'h012. ALU_flag=1, Target=10'h3FE -> 10'h010.
- From PC=10'h3FF with no branch -> ProgCtr wraps to 0.
- From PC=5: Call Target=10'h040 -> PC=10'h040, depth 1. Call Target=10'h080 -> PC=10'h080, depth 2. Ret -> 10'h041. Ret -> 10'h006, depth 0. Ret again -> 10'h007, StackErr=1 (sticky).
- Five Calls with STACK_DEPTH=4 -> depth saturates at 4, 5th call still jumps, StackErr=1. Stall=1 with Call=1 -> PC/depth unchanged. Call and Ret together -> Ret behaviour.
- Halt in RUN -> Done=1 next edge, PC frozen despite BranchAbs. Start pulse -> Done=0, depth=0, StackErr=0, increment resumes. Assert Reset mid-Call -> all outputs immediately at reset values.
